// File: rtl/vga_text_engine.sv
// vga_text_engine: parametrised VGA text renderer with a 4-cycle fetch pipeline.
// Optional VGA_TEXT_BLINK_ATTR_EN: text_data[15] becomes a per-character blink bit.
module vga_text_engine #(
  parameter int   h_sync       = 112,
  parameter int   h_back       = 248,
  parameter int   h_disp       = 1280,
  parameter int   h_front      = 48,
  parameter int   v_sync       = 3,
  parameter int   v_back       = 38,
  parameter int   v_disp       = 1024,
  parameter int   v_front      = 1,
  parameter int   cell_w       = 8,
  parameter int   cell_h       = 16,
  parameter int   color_bits   = 4,
  parameter logic sync_pol     = 1'b1,
  parameter int   blink_frames = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic [$clog2(h_disp/cell_w)-1:0] cursor_x,
  input  logic [$clog2(v_disp/cell_h)-1:0] cursor_y,
  input  logic cursor_en,
  output logic [$clog2((h_disp/cell_w)*(v_disp/cell_h))-1:0] text_addr,
  input  logic [15:0] text_data,
  output logic [8+$clog2(cell_h)-1:0] font_addr,
  input  logic [cell_w-1:0] font_data,
  output logic [color_bits-1:0] vga_r,
  output logic [color_bits-1:0] vga_g,
  output logic [color_bits-1:0] vga_b,
  output logic vga_hs,
  output logic vga_vs,
  output logic frame_start
);

  localparam int H_TOT = h_sync + h_back + h_disp + h_front;
  localparam int V_TOT = v_sync + v_back + v_disp + v_front;
  localparam int H_ACT = h_sync + h_back;
  localparam int V_ACT = v_sync + v_back;
  localparam int COLS  = h_disp / cell_w;
  localparam int ROWS  = v_disp / cell_h;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int CXW   = $clog2(COLS);
  localparam int CYW   = $clog2(ROWS);
  localparam int AW    = $clog2(COLS * ROWS);
  localparam int RW    = $clog2(cell_h);
  localparam int XW    = $clog2(cell_w);
  localparam int FW    = $clog2(blink_frames) + 1;

  typedef struct packed {
    logic           disp;
    logic [CXW-1:0] col;
    logic [CYW-1:0] row;
  } pos_t;

  function automatic pos_t locate(
    input logic [HW-1:0] h,
    input logic [VW-1:0] v
  );
    int x;
    int y;
    x = int'(h) - H_ACT;
    y = int'(v) - V_ACT;
    locate = '0;
    if (x >= 0 && x < h_disp && y >= 0 && y < v_disp) begin
      locate.disp = 1'b1;
      locate.col  = CXW'(x / cell_w);
      locate.row  = CYW'(y / cell_h);
    end
  endfunction

  function automatic logic [color_bits-1:0] chan(
    input logic on,
    input logic bright
  );
    logic [color_bits-1:0] full;
    full = '1;
    if (!on)
      chan = '0;
    else if (bright)
      chan = full;
    else
      chan = full >> 1;
  endfunction

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          h_end, v_end;

  assign h_end = h_cnt == HW'(H_TOT - 1);
  assign v_end = v_cnt == VW'(V_TOT - 1);

  always_comb begin
    h_nxt = h_end ? '0 : h_cnt + 1'b1;
    v_nxt = v_cnt;
    if (h_end)
      v_nxt = v_end ? '0 : v_cnt + 1'b1;
  end

  // The RAM address is loaded from the next count so it lines up with S0.
  pos_t pn, p0;
  assign pn = locate(h_nxt, v_nxt);
  assign p0 = locate(h_cnt, v_cnt);

  logic [CXW-1:0] cur_x;
  logic [CYW-1:0] cur_y;
  logic           cur_en;
  logic [FW-1:0]  fcnt;
  logic           blink_phase;

  logic [XW-1:0] xo0;
  logic [RW-1:0] yr0;
  logic          hit0;

  assign xo0  = XW'((int'(h_cnt) - H_ACT) % cell_w);
  assign yr0  = RW'((int'(v_cnt) - V_ACT) % cell_h);
  assign hit0 = cur_en && blink_phase && p0.disp &&
                p0.col == cur_x && p0.row == cur_y &&
                int'(yr0) >= cell_h - 2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      cur_en      <= 1'b0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      text_addr   <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (h_cnt == '0 && v_cnt == '0) begin
        cur_x  <= cursor_x;
        cur_y  <= cursor_y;
        cur_en <= cursor_en;
      end
      if (h_end && v_end) begin
        if (fcnt == FW'(blink_frames - 1)) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
      if (pn.disp)
        text_addr <= AW'(int'(pn.row) * COLS + int'(pn.col));
    end
  end

  logic [3:0] bg_w;
  logic       blank_w;

`ifdef VGA_TEXT_BLINK_ATTR_EN
  assign bg_w    = {1'b0, text_data[14:12]};
  assign blank_w = text_data[15] & ~blink_phase;
`else
  assign bg_w    = text_data[15:12];
  assign blank_w = 1'b0;
`endif

  logic          s1_disp, s1_cur, s1_hs, s1_vs, s1_fs;
  logic [XW-1:0] s1_xo;
  logic [RW-1:0] s1_yr;
  logic          s2_disp, s2_cur, s2_blank, s2_hs, s2_vs, s2_fs;
  logic [XW-1:0] s2_xo;
  logic [3:0]    s2_fg, s2_bg;
  logic          s3_disp, s3_cur, s3_blank, s3_hs, s3_vs, s3_fs;
  logic [XW-1:0] s3_xo;
  logic [3:0]    s3_fg, s3_bg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_disp   <= 1'b0;
      s1_cur    <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_fs     <= 1'b0;
      s1_xo     <= '0;
      s1_yr     <= '0;
      font_addr <= '0;
      s2_disp   <= 1'b0;
      s2_cur    <= 1'b0;
      s2_blank  <= 1'b0;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
      s2_fs     <= 1'b0;
      s2_xo     <= '0;
      s2_fg     <= '0;
      s2_bg     <= '0;
      s3_disp   <= 1'b0;
      s3_cur    <= 1'b0;
      s3_blank  <= 1'b0;
      s3_hs     <= 1'b0;
      s3_vs     <= 1'b0;
      s3_fs     <= 1'b0;
      s3_xo     <= '0;
      s3_fg     <= '0;
      s3_bg     <= '0;
    end else begin
      s1_disp  <= p0.disp;
      s1_cur   <= hit0;
      s1_hs    <= int'(h_cnt) < h_sync;
      s1_vs    <= int'(v_cnt) < v_sync;
      s1_fs    <= int'(h_cnt) == H_ACT && int'(v_cnt) == V_ACT;
      s1_xo    <= xo0;
      s1_yr    <= yr0;
      if (s1_disp)
        font_addr <= {text_data[7:0], s1_yr};
      s2_disp  <= s1_disp;
      s2_cur   <= s1_cur;
      s2_blank <= blank_w;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
      s2_fs    <= s1_fs;
      s2_xo    <= s1_xo;
      s2_fg    <= text_data[11:8];
      s2_bg    <= bg_w;
      s3_disp  <= s2_disp;
      s3_cur   <= s2_cur;
      s3_blank <= s2_blank;
      s3_hs    <= s2_hs;
      s3_vs    <= s2_vs;
      s3_fs    <= s2_fs;
      s3_xo    <= s2_xo;
      s3_fg    <= s2_fg;
      s3_bg    <= s2_bg;
    end
  end

  logic [3:0] idx;
  logic       pix;

  always_comb begin
    pix = font_data[XW'(cell_w - 1) - s3_xo];
    idx = pix ? s3_fg : s3_bg;
    if (s3_blank)
      idx = s3_bg;
    if (s3_cur)
      idx = s3_fg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= ~sync_pol;
      vga_vs      <= ~sync_pol;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= s3_disp ? chan(idx[2], idx[3]) : '0;
      vga_g       <= s3_disp ? chan(idx[1], idx[3]) : '0;
      vga_b       <= s3_disp ? chan(idx[0], idx[3]) : '0;
      vga_hs      <= s3_hs ? sync_pol : ~sync_pol;
      vga_vs      <= s3_vs ? sync_pol : ~sync_pol;
      frame_start <= s3_fs;
    end
  end

endmodule
